issue_allocator: RTL
====================

ISSUE_ALLOCATOR -- requirements
Module: issue_allocator

Interface
REQ-001 Parameter DATA_W, 18, width of broadcast pixel and weight samples (signed).
REQ-002 Parameter ACC_W, 48, accumulator/result width (signed).
REQ-003 Parameter WADDR_W, 14, weight memory address width (covers 25*384 = 9600 entries).
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pos_x, pos_y  input  8 each  window centre from positioner, sampled when pos_select=1.
REQ-007 pos_select  input  1  one-cycle strobe addressing this allocator.
REQ-008 filter_halfsize  input  2  h; window is (2h+1)x(2h+1); valid h = 1 or 2.
REQ-009 image_depth  input  9  number of z planes D, 3..384.
REQ-010 issue_x, issue_y  input  8 each  coordinate of broadcast sample, in padded frame.
REQ-011 issue_data  input  DATA_W  broadcast sample.
REQ-012 issue_en  input  1  sample valid this cycle.
REQ-013 issue_block  output  1  request that broadcast hold its current sample.
REQ-014 weight_addr  output  WADDR_W  filter weight read address.
REQ-015 weight_data  input  DATA_W  weight; returned exactly 1 cycle after weight_addr.
REQ-016 result  output  ACC_W  completed dot product.
REQ-017 result_valid  output  1  result held valid until acknowledged.
REQ-018 result_ack  input  1  consumer takes result this cycle when result_valid=1.

Function
REQ-019 Broadcast order is fixed: per pixel (y-major, then x), all z from 0 to D-1 on consecutive issue_en cycles; padding pixels are broadcast with data 0.
REQ-020 States: IDLE, ARMED, DRAIN, HOLD; reset state IDLE.
REQ-021 IDLE + pos_select: latch pos_x, pos_y, h, D; clear accumulator, z counter, hit counter; go ARMED next cycle.
REQ-022 pos_select in ARMED, DRAIN or HOLD is ignored.
REQ-023 Hit = issue_en and |issue_x-pos_x| <= h and |issue_y-pos_y| <= h (unsigned compare on 9-bit differences, no wrap).
REQ-024 On a hit, z = internal counter; counter increments per hit, returns to 0 after D-1.
REQ-025 weight_addr = ((dy*(2h+1)+dx)*D + z), dx = issue_x-pos_x+h, dy = issue_y-pos_y+h; registered, issued the cycle after the hit.
REQ-026 Pipeline: stage1 registers sample and address; stage2 multiplies sample by weight_data (2*DATA_W product, sign-extended); stage3 adds into accumulator; accumulator wraps modulo 2^ACC_W.
REQ-027 Non-hit and issue_en=0 cycles produce no accumulation; issue_en while issue_block=1 is ignored.
REQ-028 ARMED -> DRAIN on the cycle the hit counter reaches (2h+1)^2*D.
REQ-029 DRAIN lasts until the last product is accumulated (3 cycles), then: if result_valid=0 or result_ack=1 this cycle, load result, result_valid=1, go IDLE; otherwise go HOLD.
REQ-030 HOLD: issue_block=1; on result_ack, load result, go IDLE next cycle.
REQ-031 issue_block = 1 only in HOLD; combinational from state register.
REQ-032 result_valid clears on result_ack unless a new result is loaded in the same cycle, in which case it stays 1 with the new value.
REQ-033 Hits arriving in DRAIN or HOLD are not accumulated.

Reset
REQ-034 rst in any state: state=IDLE, result=0, result_valid=0, issue_block=0, weight_addr=0, accumulator, counters and pipeline valids cleared, in-flight samples discarded.

Configuration
REQ-035 Macro ISSUE_ALLOCATOR_RELU_EN defined: value loaded into result is max(acc, 0); undefined: raw signed accumulator loaded.

Structure
REQ-036 Shared package holds DATA_W, ACC_W and WADDR_W defaults, the state encoding, and the window-size function (2h+1)^2.
REQ-037 One sub-module, issue_allocator_mac: the 3-stage multiply-accumulate pipeline with clear and drain-empty flag.

Verification
REQ-038 h=1, D=3, pos=(5,5); broadcast a 10x10 frame, data=1, all weights=1 -> result=27, result_valid after last hit plus 3 cycles.
REQ-039 h=2, D=3, pos=(2,2); weights = address index, data=1 -> result = sum 0..74 = 2775.
REQ-040 Result unacked from previous round, new round completes -> HOLD, issue_block=1, broadcast stalls; ack -> new result loaded, issue_block=0 next cycle.
REQ-041 pos_select pulsed while ARMED with pos=(9,9) -> ignored, original window result unchanged.
REQ-042 data=-1, weights=1, h=1, D=3 -> result=0 with ISSUE_ALLOCATOR_RELU_EN, -27 without.
REQ-043 rst asserted mid-ARMED after 10 hits -> next cycle all outputs 0, IDLE; re-positioned round gives the full correct sum.

Source files
------------

// File: rtl/issue_allocator_pkg.sv
// Shared definitions for the issue allocator: default widths, FSM state
// encoding and the filter window size helper.
package issue_allocator_pkg;

   localparam int DEF_DATA_W  = 18;
   localparam int DEF_ACC_W   = 48;
   localparam int DEF_WADDR_W = 14;

   // Hit counter width; a round holds at most 25 * 384 = 9600 hits
   localparam int HIT_W = 14;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // Number of pixels in a (2h+1)x(2h+1) window
   function automatic logic [5:0] windowSize(input logic [1:0] h);
      logic [5:0] side;
      side = {3'b000, h, 1'b1};
      return side * side;
   endfunction

endpackage

// File: rtl/issue_allocator_if.sv
// Bus between the allocator and its surroundings: positioner strobe,
// sample broadcast with back-pressure, weight memory port and result handshake.
interface issue_allocator_if
   import issue_allocator_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int WADDR_W = DEF_WADDR_W
) ();

   logic        [7:0]         pos_x;
   logic        [7:0]         pos_y;
   logic                      pos_select;
   logic        [1:0]         filter_halfsize;
   logic        [8:0]         image_depth;
   logic        [7:0]         issue_x;
   logic        [7:0]         issue_y;
   logic signed [DATA_W-1:0]  issue_data;
   logic                      issue_en;
   logic                      issue_block;
   logic        [WADDR_W-1:0] weight_addr;
   logic signed [DATA_W-1:0]  weight_data;
   logic signed [ACC_W-1:0]   result;
   logic                      result_valid;
   logic                      result_ack;

   modport master (
      output pos_x, pos_y, pos_select, filter_halfsize, image_depth,
      output issue_x, issue_y, issue_data, issue_en, weight_data, result_ack,
      input  issue_block, weight_addr, result, result_valid
   );

   modport slave (
      input  pos_x, pos_y, pos_select, filter_halfsize, image_depth,
      input  issue_x, issue_y, issue_data, issue_en, weight_data, result_ack,
      output issue_block, weight_addr, result, result_valid
   );

endinterface

// File: rtl/issue_allocator_mac.sv
// Multiply-accumulate pipeline: stage 1 captures the sample alongside the
// weight address, a one-cycle alignment register waits for the weight memory,
// stage 2 registers the product and stage 3 folds it into the accumulator.
module issue_allocator_mac
   import issue_allocator_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     valid_i,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic signed [DATA_W-1:0] weight_i,
   output logic                     drainEmpty_o,
   output logic signed [ACC_W-1:0]  accSum_o
);

   logic                      s1Valid_q;
   logic signed [DATA_W-1:0]  s1Sample_q;
   logic                      alignValid_q;
   logic signed [DATA_W-1:0]  alignSample_q;
   logic                      s2Valid_q;
   logic signed [ACC_W-1:0]   s2Prod_q;
   logic signed [ACC_W-1:0]   acc_q;

   logic signed [2*DATA_W-1:0] sampleExt;
   logic signed [2*DATA_W-1:0] weightExt;
   logic signed [2*DATA_W-1:0] prodFull;
   logic signed [ACC_W-1:0]    prodExt;

   assign sampleExt = {{DATA_W{alignSample_q[DATA_W-1]}}, alignSample_q};
   assign weightExt = {{DATA_W{weight_i[DATA_W-1]}}, weight_i};
   assign prodFull  = sampleExt * weightExt;
   assign prodExt   = {{(ACC_W-2*DATA_W){prodFull[2*DATA_W-1]}}, prodFull};

   // Value the accumulator takes at the next edge; equals the final sum in the
   // cycle where the last product sits in the final stage.
   assign accSum_o     = s2Valid_q ? (acc_q + s2Prod_q) : acc_q;
   assign drainEmpty_o = !(s1Valid_q || alignValid_q);

   // Advance the pipeline; clear drops everything and zeroes the sum
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         s1Valid_q     <= 1'b0;
         s1Sample_q    <= '0;
         alignValid_q  <= 1'b0;
         alignSample_q <= '0;
         s2Valid_q     <= 1'b0;
         s2Prod_q      <= '0;
         acc_q         <= '0;
      end else begin
         s1Valid_q     <= valid_i;
         s1Sample_q    <= sample_i;
         alignValid_q  <= s1Valid_q;
         alignSample_q <= s1Sample_q;
         s2Valid_q     <= alignValid_q;
         s2Prod_q      <= prodExt;
         acc_q         <= accSum_o;
      end
   end

endmodule

// File: rtl/issue_allocator.sv
// Issue allocator: watches the pixel broadcast for samples inside its filter
// window, fetches the matching weight and accumulates one dot product per
// round. Optional macro ISSUE_ALLOCATOR_RELU_EN clamps negative results to 0.
module issue_allocator
   import issue_allocator_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int WADDR_W = DEF_WADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   issue_allocator_if.slave  bus
);

   logic [1:0]               state_q, state_d;
   logic [7:0]               posX_q, posY_q;
   logic [1:0]               half_q;
   logic [8:0]               depth_q;
   logic [8:0]               zCnt_q;
   logic [HIT_W-1:0]         hitCnt_q;
   logic [WADDR_W-1:0]       weightAddr_q;
   logic signed [ACC_W-1:0]  result_q;
   logic                     resultValid_q;

   logic [8:0]               diffX, diffY;
   logic [7:0]               offXFull, offYFull;
   logic [2:0]               side;
   logic [5:0]               cellIdx;
   logic [WADDR_W-1:0]       addrNext;
   logic [HIT_W-1:0]         totalHits;
   logic                     startRound, hit, lastHit, loadNow, drainEmpty;
   logic signed [ACC_W-1:0]  accSum, loadValue;

   assign diffX = (bus.issue_x >= posX_q) ? ({1'b0, bus.issue_x} - {1'b0, posX_q})
                                          : ({1'b0, posX_q} - {1'b0, bus.issue_x});
   assign diffY = (bus.issue_y >= posY_q) ? ({1'b0, bus.issue_y} - {1'b0, posY_q})
                                          : ({1'b0, posY_q} - {1'b0, bus.issue_y});

   assign startRound = (state_q == ST_IDLE) && bus.pos_select;
   assign hit = bus.issue_en && (state_q == ST_ARMED)
                && (diffX <= {7'b0, half_q}) && (diffY <= {7'b0, half_q});

   assign offXFull  = bus.issue_x + {6'b0, half_q} - posX_q;
   assign offYFull  = bus.issue_y + {6'b0, half_q} - posY_q;
   assign side      = {half_q, 1'b1};
   assign cellIdx   = {3'b0, offYFull[2:0]} * {3'b0, side} + {3'b0, offXFull[2:0]};
   assign addrNext  = WADDR_W'(cellIdx) * WADDR_W'(depth_q) + WADDR_W'(zCnt_q);
   assign totalHits = HIT_W'(windowSize(half_q)) * HIT_W'(depth_q);
   assign lastHit   = hit && ((hitCnt_q + HIT_W'(1)) == totalHits);

   assign loadNow = ((state_q == ST_DRAIN) && drainEmpty && (!resultValid_q || bus.result_ack))
                    || ((state_q == ST_HOLD) && bus.result_ack);

`ifdef ISSUE_ALLOCATOR_RELU_EN
   assign loadValue = accSum[ACC_W-1] ? '0 : accSum;
`else
   assign loadValue = accSum;
`endif

   assign bus.issue_block  = (state_q == ST_HOLD);
   assign bus.weight_addr  = weightAddr_q;
   assign bus.result       = result_q;
   assign bus.result_valid = resultValid_q;

   issue_allocator_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (startRound),
      .valid_i      (hit),
      .sample_i     (bus.issue_data),
      .weight_i     (bus.weight_data),
      .drainEmpty_o (drainEmpty),
      .accSum_o     (accSum)
   );

   // Round sequencing: arm on the strobe, drain after the final hit, hold if the old result is unread
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.pos_select) state_d = ST_ARMED;
         ST_ARMED: if (lastHit) state_d = ST_DRAIN;
         ST_DRAIN: if (drainEmpty) state_d = (!resultValid_q || bus.result_ack) ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (bus.result_ack) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Window capture, depth/hit counters and the registered weight address
   always_ff @(posedge clk) begin
      if (rst) begin
         posX_q       <= '0;
         posY_q       <= '0;
         half_q       <= '0;
         depth_q      <= '0;
         zCnt_q       <= '0;
         hitCnt_q     <= '0;
         weightAddr_q <= '0;
      end else if (startRound) begin
         posX_q   <= bus.pos_x;
         posY_q   <= bus.pos_y;
         half_q   <= bus.filter_halfsize;
         depth_q  <= bus.image_depth;
         zCnt_q   <= '0;
         hitCnt_q <= '0;
      end else if (hit) begin
         zCnt_q       <= (zCnt_q == depth_q - 9'd1) ? 9'd0 : zCnt_q + 9'd1;
         hitCnt_q     <= hitCnt_q + HIT_W'(1);
         weightAddr_q <= addrNext;
      end
   end

   // Result register: a fresh load wins over an acknowledge in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q      <= '0;
         resultValid_q <= 1'b0;
      end else if (loadNow) begin
         result_q      <= loadValue;
         resultValid_q <= 1'b1;
      end else if (bus.result_ack) begin
         resultValid_q <= 1'b0;
      end
   end

endmodule
